// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : MEM-stage data-memory responder for the pipelined RV32 CPU.
//                Accepts one load/store at a time, stalls the pipeline while
//                the access is in flight, and acks after a fixed latency.
//                Optional macro DMEM_LAST_HIT_EN adds a one-entry
//                last-load tag that lets a repeated load complete in 1 cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int         C_IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] C_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_cnt;
    logic [C_IDX_W-1:0]   r_idx;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic                 r_store;
    logic                 r_err;
    logic                 r_resp_err;
    logic [31:0]          r_rdata;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_req;
    logic [C_IDX_W-1:0]   w_in_idx;
    logic                 w_in_err;
    logic                 w_use_in;
    logic [C_IDX_W-1:0]   w_acc_idx;
    logic [31:0]          w_acc_wdata;
    logic [3:0]           w_acc_wstrb;
    logic                 w_acc_store;
    logic                 w_acc_err;
    logic                 w_enter_resp;
    logic                 w_tag_hit;
    logic [31:0]          w_hit_data;
    logic                 w_unused_addr;

    // Address bits above the array index are intentionally ignored (wrap).
    assign w_unused_addr = &{1'b0, addr_i[31:C_IDX_W+2]};

    assign w_req    = mem_read_i | mem_write_i;
    assign w_in_idx = addr_i[2 +: C_IDX_W];
    // Loads must be word aligned; a store off word alignment may touch one byte only.
    assign w_in_err = (addr_i[1:0] != 2'b00) &&
                      (!mem_write_i || ((wstrb_i & (wstrb_i - 4'd1)) != 4'd0));

    // Accesses completed straight out of IDLE use the live inputs, otherwise the latched copy.
    assign w_use_in     = (r_state == S_IDLE);
    assign w_acc_idx    = w_use_in ? w_in_idx    : r_idx;
    assign w_acc_wdata  = w_use_in ? wdata_i     : r_wdata;
    assign w_acc_wstrb  = w_use_in ? wstrb_i     : r_wstrb;
    assign w_acc_store  = w_use_in ? mem_write_i : r_store;
    assign w_acc_err    = w_use_in ? w_in_err    : r_err;
    assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);

    assign ack_o   = (r_state == S_RESP);
    assign err_o   = (r_state == S_RESP) && r_resp_err;
    assign rdata_o = r_rdata;

    // Next-state selection and pipeline stall request.
    always_comb begin
        w_state_next = r_state;
        stall_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    stall_o = 1'b1;
                    if ((LATENCY == 1) || w_tag_hit) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                stall_o = 1'b1;
                if ((r_cnt == 4'd1) || (r_cnt == 4'd0)) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, latency counter, request latch and response data.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rdata    <= 32'd0;
            r_resp_err <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_store    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && w_req) begin
                r_cnt   <= C_LAT_M1;
                r_idx   <= w_in_idx;
                r_wdata <= wdata_i;
                r_wstrb <= wstrb_i;
                r_store <= mem_write_i;
                r_err   <= w_in_err;
            end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_resp_err <= w_acc_err;
                if (w_acc_store || w_acc_err) begin
                    r_rdata <= 32'd0;
                end else if (w_tag_hit) begin
                    r_rdata <= w_hit_data;
                end else begin
                    r_rdata <= r_mem[w_acc_idx];
                end
            end
        end
    end

    // Byte-masked array write; a reset on the commit edge suppresses the store.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_enter_resp && w_acc_store && !w_acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_wstrb[b]) begin
                    r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_LAST_HIT_EN
    logic                 r_tag_valid;
    logic [C_IDX_W-1:0]   r_tag_idx;
    logic [31:0]          r_tag_data;

    assign w_tag_hit  = (r_state == S_IDLE) && r_tag_valid && mem_read_i && !mem_write_i &&
                        !w_in_err && (r_tag_idx == w_in_idx);
    assign w_hit_data = r_tag_data;

    // Last-load tag: filled by loads, merged by matching stores, dropped on error.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_tag_valid <= 1'b0;
            r_tag_idx   <= '0;
            r_tag_data  <= 32'd0;
        end else if (w_enter_resp) begin
            if (w_acc_err) begin
                r_tag_valid <= 1'b0;
            end else if (!w_acc_store) begin
                r_tag_valid <= 1'b1;
                r_tag_idx   <= w_acc_idx;
                r_tag_data  <= w_tag_hit ? r_tag_data : r_mem[w_acc_idx];
            end else if (r_tag_valid && (r_tag_idx == w_acc_idx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_acc_wstrb[b]) begin
                        r_tag_data[8*b +: 8] <= w_acc_wdata[8*b +: 8];
                    end
                end
            end
        end
    end
`else
    assign w_tag_hit  = 1'b0;
    assign w_hit_data = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder (256 words,
//                latency 3). Directed scenarios followed by random accesses
//                checked against a word-array model with byte strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int C_DEPTH = 256;
    localparam int C_LAT   = 3;
`ifdef DMEM_LAST_HIT_EN
    localparam bit C_TAG_EN = 1'b1;
`else
    localparam bit C_TAG_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    int          tests;
    int          fails;

    // Reference model: word array plus the index of the last successful load.
    logic [31:0] model [C_DEPTH];
    bit          tag_valid;
    logic [7:0]  tag_idx;

    data_mem_responder #(
        .DEPTH_WORDS (C_DEPTH),
        .LATENCY     (C_LAT)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wstrb_i     (wstrb_i),
        .rdata_o     (rdata_o),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .stall_o     (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        addr_i      = 32'd0;
        wdata_i     = 32'd0;
        wstrb_i     = 4'd0;
    endtask

    // One complete request: drive, count cycles to ack, check response, update model.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st, input string tag);
        logic [7:0]  idx;
        logic        err;
        int          lat;
        int          n;
        logic [31:0] exp_rd;
        idx    = a[9:2];
        err    = (a[1:0] != 2'b00) && (!wr || ($countones(st) > 1));
        lat    = (C_TAG_EN && tag_valid && rd && !wr && !err && (tag_idx == idx)) ? 1 : C_LAT;
        exp_rd = (wr || err) ? 32'd0 : model[idx];

        @(negedge clk);
        mem_read_i  = rd;
        mem_write_i = wr;
        addr_i      = a;
        wdata_i     = wd;
        wstrb_i     = st;
        #1;
        chk({tag, "_stall_accept"}, 32'(stall_o), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ack_o && n < lat) chk({tag, "_stall_busy"}, 32'(stall_o), 32'd1);
        end while (!ack_o && n < 20);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_err"}, 32'(err_o), 32'(err));
        chk({tag, "_rdata"}, rdata_o, exp_rd);
        chk({tag, "_stall_resp"}, 32'(stall_o), 32'd0);
        idle_inputs();

        if (err) begin
            tag_valid = 1'b0;
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
            tag_valid = 1'b1;
            tag_idx   = idx;
        end
    endtask

    initial begin
        logic [31:0] old20;
        tests     = 0;
        fails     = 0;
        tag_valid = 1'b0;
        tag_idx   = 8'd0;
        rst_i     = 1'b0;
        idle_inputs();

        // Reset held low for two edges, then released.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_ack", 32'(ack_o), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);

        // Initialise the words the bench will read from.
        for (int i = 0; i < 16; i++)
            access(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, "fill");

        // Full store then load back.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st_full");
        access(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, "ld_full");
        chk("ld_full_value", rdata_o, 32'hDEADBEEF);

        // Single-byte merge.
        access(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, "st_byte");
        access(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, "ld_byte");
        chk("ld_byte_value", rdata_o, 32'hDEADBEAA);

        // Misaligned load errors; aligned word 0x400 wraps to index 0.
        access(1'b1, 1'b0, 32'h402, 32'd0, 4'h0, "ld_misal");
        access(1'b1, 1'b0, 32'h400, 32'd0, 4'h0, "ld_wrap");

        // Both request bits high behaves as a store; empty strobe changes nothing.
        access(1'b1, 1'b1, 32'h14, 32'h12345678, 4'hF, "st_both");
        access(1'b0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, "st_nostrb");
        access(1'b1, 1'b0, 32'h14, 32'd0, 4'h0, "ld_both");
        chk("ld_both_value", rdata_o, 32'h12345678);

        // Back-to-back loads of the same word (second may hit the tag).
        access(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, "ld_rep1");
        access(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, "ld_rep2");

        // Store aborted by reset in the cycle after accept.
        old20 = model[8];
        @(negedge clk);
        mem_write_i = 1'b1;
        addr_i      = 32'h20;
        wdata_i     = ~old20;
        wstrb_i     = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        idle_inputs();
        tag_valid = 1'b0;
        #1;
        chk("abort_ack", 32'(ack_o), 32'd0);
        chk("abort_stall", 32'(stall_o), 32'd0);
        access(1'b1, 1'b0, 32'h20, 32'd0, 4'h0, "ld_abort");
        chk("ld_abort_value", rdata_o, old20);

        // Random mix of loads, stores, misaligned and wrapped addresses.
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [31:0] a;
            logic [1:0]  low;
            kind = $urandom_range(0, 2);
            low  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            a    = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2) | 32'(low);
            access(kind != 1, kind != 0, a, $urandom, 4'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
